// File: rtl/imem_loader.sv
// Byte-stream loader for the 9-bit instruction memory: assembles low/high byte
// pairs and writes them to consecutive addresses, holding the core off while busy.
module imem_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    prog_len,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state, state_d;
  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] length;
  logic [7:0]          low_byte;
  logic                len_ok;
  logic                accept;
  logic                frame_err;

  // count is one bit wider than the address so a full 4096-entry image is legal
  assign len_ok    = (prog_len != '0) && (prog_len <= MAX_LEN);
  assign accept    = in_valid && in_ready;
  assign frame_err = (in_data[7:1] != 7'd0);
  assign busy      = (state != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d  = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE:  if (start && len_ok) state_d = S_LOW;
      S_LOW: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_HIGH;
      end
      S_HIGH: begin
        in_ready = 1'b1;
        if (in_valid) state_d = frame_err ? S_IDLE : S_WRITE;
      end
      S_WRITE: state_d = (count + 1'b1 == length) ? S_DONE : S_LOW;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      length   <= '0;
      low_byte <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_d;
      wr_en <= (state_d == S_WRITE);
      done  <= (state_d == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              length <= prog_len;
              count  <= '0;
              error  <= 1'b0;
            end else begin
              error  <= 1'b1;
            end
          end
        end
        S_LOW: if (accept) low_byte <= in_data;
        S_HIGH: begin
          if (accept) begin
            if (frame_err) begin
              error <= 1'b1;
            end else begin
              wr_addr <= count[ADDR_WIDTH-1:0];
              wr_data <= {in_data[0], low_byte};
            end
          end
        end
        S_WRITE: count <= count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte streams with random gaps,
// checked against a list-of-writes model built from the byte-pair rules.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] prog_len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [8:0]  wr_data;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_WIDTH(12), .INSTR_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [20:0] got_q[$];
  logic [7:0]  lo_q[$];
  logic [7:0]  hi_q[$];
  int          done_cnt, done_cyc, first_wr_cyc, last_wr_cyc, rdy_bad;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back({wr_addr, wr_data});
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (in_ready) rdy_bad++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #(600_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    rdy_bad      = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},    32'(wr_en),    0);
    check({tag, "_done"},     32'(done),     0);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_error"},    32'(error),    0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_wr_addr"},  32'(wr_addr),  0);
    check({tag, "_wr_data"},  32'(wr_data),  0);
  endtask

  task automatic pulse_start(input logic [12:0] len);
    start    = 1'b1;
    prog_len = len;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap);
    int gap;
    bit ok;
    gap = $urandom_range(max_gap, min_gap);
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("handshake", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 1);
  endtask

  // Random instruction stream; frame_at >= 0 corrupts that high byte.
  task automatic gen_stream(input int n, input int frame_at);
    lo_q.delete();
    hi_q.delete();
    for (int i = 0; i < n; i++) begin
      lo_q.push_back(8'($urandom_range(255, 0)));
      if (i == frame_at) hi_q.push_back(8'($urandom_range(255, 2)));
      else               hi_q.push_back(8'($urandom_range(1, 0)));
    end
  endtask

  // Model: instruction i goes to address i with data {hi[0], lo}; the first
  // high byte with any of bits 7:1 set ends the load with error and no write.
  task automatic run_load(input string tag, input int len, input int min_gap, input int max_gap,
                          input bit check_rate);
    logic [20:0] exp_q[$];
    logic [11:0] a;
    bit          exp_err;
    int          n_sent;
    exp_err = 1'b0;
    n_sent  = 0;
    for (int i = 0; i < len; i++) begin
      n_sent++;
      if (hi_q[i][7:1] != 7'd0) begin
        exp_err = 1'b1;
        break;
      end
      a = i[11:0];
      exp_q.push_back({a, hi_q[i][0], lo_q[i]});
    end
    clear_mon();
    pulse_start(13'(len));
    for (int i = 0; i < n_sent; i++) begin
      send_byte(lo_q[i], min_gap, max_gap);
      send_byte(hi_q[i], min_gap, max_gap);
    end
    wait_idle();
    check({tag, "_n_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done_cnt"}, done_cnt, exp_err ? 0 : 1);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_rdy_in_write"}, rdy_bad, 0);
    if (!exp_err) check({tag, "_done_cycle"}, done_cyc, last_wr_cyc + 1);
    if (check_rate && exp_q.size() > 1)
      check({tag, "_write_span"}, last_wr_cyc - first_wr_cyc, 3 * (exp_q.size() - 1));
  endtask

  task automatic poke_start();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    check("poke_saw_write", 32'(seen), 1);
    if (seen) begin
      start    = 1'b1;
      prog_len = 13'd1;
      @(posedge clk); #1;
      prog_len = 13'd0;
      @(posedge clk); #1;
      start    = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    reset    = 1'b1;
    start    = 1'b0;
    prog_len = '0;
    in_data  = '0;
    in_valid = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Two-instruction directed load, back-to-back then with 5-cycle gaps.
    lo_q = '{8'h34, 8'hA5};
    hi_q = '{8'h01, 8'h00};
    run_load("two", 2, 0, 0, 1'b1);
    run_load("two_gap", 2, 5, 5, 1'b0);

    // Framing error, then a legal start clears it.
    lo_q = '{8'h10, 8'h00, 8'h00};
    hi_q = '{8'h02, 8'h00, 8'h00};
    run_load("frame", 3, 0, 2, 1'b0);
    check("frame_busy", 32'(busy), 0);
    gen_stream(1, -1);
    run_load("after_frame", 1, 0, 2, 1'b0);

    // Illegal lengths: 0 and 4097 both flag error without leaving IDLE.
    clear_mon();
    pulse_start(13'd0);
    @(negedge clk);
    check("len0_error", 32'(error), 1);
    check("len0_busy", 32'(busy), 0);
    gen_stream(1, -1);
    run_load("between_bad", 1, 0, 0, 1'b0);
    clear_mon();
    pulse_start(13'd4097);
    repeat (3) @(negedge clk);
    check("len4097_error", 32'(error), 1);
    check("len4097_busy", 32'(busy), 0);
    check("bad_len_writes", got_q.size(), 0);

    // Reset mid-load after the first write.
    clear_mon();
    pulse_start(13'd4);
    send_byte(8'hFF, 0, 0);
    send_byte(8'h01, 0, 0);
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    check("midreset_saw_write", 32'(seen), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (5) @(negedge clk);
    check("midreset_writes", got_q.size(), 1);
    #1;
    gen_stream(1, -1);
    run_load("after_reset", 1, 0, 0, 1'b0);

    // Random loads with random gaps, one with a framing error.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(40, 1);
      gen_stream(n, (r == 3) ? int'($urandom_range(n - 1, 0)) : -1);
      run_load("rand", n, 0, 3, 1'b0);
    end

    // start re-pulsed during WRITE (len 1) and LOW (len 0) must be ignored.
    gen_stream(3, -1);
    fork
      run_load("poke", 3, 2, 4, 1'b0);
      poke_start();
    join

    // Full 4096-entry image, back-to-back stream.
    gen_stream(4096, -1);
    run_load("full", 4096, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writes a program image into the 9-bit-wide instruction memory from a byte stream, for example from a UART receiver or a testbench host. It is the write-side counterpart of the instruction fetch path.
- Each instruction arrives as two bytes, low byte first. It is assembled and written to consecutive addresses starting at 0.
- busy holds the core off while loading. done pulses when the image is complete.

Parameters:
ADDR_WIDTH, 12, instruction memory address width (4096 entries)
INSTR_WIDTH, 9, instruction width; fixed: low byte supplies [7:0], bit 0 of the high byte supplies [8]

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  begin load; sampled only in IDLE
prog_len  input  13  number of instructions to load; legal range 1..4096
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte; handshake completes when in_valid && in_ready on a rising edge
wr_en  output  1  instruction memory write strobe, one cycle per instruction
wr_addr  output  12  write address
wr_data  output  9  write data
busy  output  1  high whenever state != IDLE; holds the core/PC
done  output  1  one-cycle pulse after the final write
error  output  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all outputs 0.
  - Internal count, latched length and low-byte register are cleared to 0.
  - Reset mid-load aborts the load immediately. No further wr_en is issued, and memory contents already written are left as they are.
- States: IDLE, LOW, HIGH, WRITE, DONE.
- IDLE: in_ready=0.
  - start with prog_len in 1..4096: latch prog_len, count=0, error=0, go to LOW.
  - start with prog_len==0 or >4096: error=1, stay in IDLE.
- LOW: in_ready=1. On handshake, latch in_data as low byte and go to HIGH.
- HIGH: in_ready=1. On handshake:
  - in_data[7:1]!=0: framing error. Set error=1, go to IDLE, no write.
  - Otherwise: register wr_data={in_data[0], low byte} and wr_addr=count, then go to WRITE.
- WRITE: in_ready=0, wr_en=1 for exactly this cycle.
  - Next cycle count increments.
  - If count+1==length, go to DONE; otherwise go to LOW.
- DONE: done=1 for this single cycle, in_ready=0, then go to IDLE.
- Cycle timing:
  - High-byte handshake at edge N puts wr_en high during cycle N..N+1.
  - The next low byte can be accepted at edge N+2.
  - Minimum of 3 cycles per instruction.
- wr_en, wr_addr, wr_data, done are registered outputs.
- wr_addr/wr_data hold their last values when wr_en=0.
- count is 13 bits, so length 4096 is legal. The last write goes to address 4095 with no wrap, and no write ever targets an address >= length.
- start while busy is ignored. It has no effect on count or error.
- in_valid gaps of any length are tolerated in LOW/HIGH; the state is held.
- in_valid while in_ready=0: the byte is not consumed. The source must hold it.
- error stays high until the next start with a legal prog_len is accepted.

Test Plan:
- Load of 2 instructions, start prog_len=2, bytes 0x34,0x01,0xA5,0x00 -> wr_en pulses with (addr 0, data 0x134) then (addr 1, data 0x0A5), done pulses once one cycle after the second write; busy then falls; error stays 0.
- Backpressure/gaps, same stream with in_valid low for 5 cycles between every byte -> identical writes; in_ready is 0 during each WRITE cycle and the held byte is accepted on the following LOW cycle.
- Framing error, prog_len=3, bytes 0x10,0x02 -> no wr_en, error=1, state back to IDLE (busy=0); a subsequent legal start clears error.
- Bad length, start with prog_len=0, then prog_len=4097 -> error=1 each time, busy stays 0, no wr_en.
- Reset mid-load, prog_len=4, reset asserted after the first write -> all outputs 0 next cycle; later start prog_len=1 writes to addr 0.
- Full image, prog_len=4096 with a random stream -> 4096 writes at addresses 0..4095 in order, data matches the assembled bytes, done pulses once.
- Start ignored while busy, start re-pulsed during LOW/WRITE -> count, length and error unchanged.
